// File: rtl/stack_ctrl.sv
// Purpose: stack command sequencer; drives the SP register block and a synchronous stack RAM,
// Latency: accept->RspValid is 1 (bound error), 2 (PUSH/SETSP) or 3 (POP/PEEK) cycles.
// Backpressure: CmdReady only in IDLE; responses are single-cycle pulses with no backpressure.
//
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   CmdValid/CmdReady/CmdOp/CmdData  command handshake (00 PUSH, 01 POP, 10 PEEK, 11 SETSP)
//   RspValid/RspErr/RspData          completion pulse, error flag, POP/PEEK result
//   SPDrive/SPSet/SPValue            SP block control (hold/inc/dec/load) and current SP
//   MemAddr/MemWe/MemRe/MemWData/MemRData  synchronous stack RAM port
module stack_ctrl #(
   parameter logic [31:0] STACK_BASE  = 32'h0000_0F00,
   parameter int unsigned STACK_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        CmdValid,
   input  logic [1:0]  CmdOp,
   input  logic [31:0] CmdData,
   output logic        CmdReady,
   output logic        RspValid,
   output logic        RspErr,
   output logic [31:0] RspData,
   output logic [1:0]  SPDrive,
   output logic [31:0] SPSet,
   input  logic [31:0] SPValue,
   output logic [31:0] MemAddr,
   output logic        MemWe,
   output logic        MemRe,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData
);

   // SP equal to STACK_TOP means every slot is occupied.
   localparam logic [31:0] STACK_TOP = STACK_BASE + 32'(STACK_DEPTH);

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_POP   = 2'b01;
   localparam logic [1:0] OP_PEEK  = 2'b10;
   localparam logic [1:0] OP_SETSP = 2'b11;

   localparam logic [1:0] DRV_HOLD = 2'b00;
   localparam logic [1:0] DRV_INC  = 2'b01;
   localparam logic [1:0] DRV_DEC  = 2'b10;
   localparam logic [1:0] DRV_LOAD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_WAIT,
      S_LOAD
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] data_q, data_d;
   logic        rsp_vld_q, rsp_vld_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        cmd_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= OP_PUSH;
         data_q     <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_err_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         data_q     <= data_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_err_q  <= rsp_err_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      data_d     = data_q;
      rsp_vld_d  = 1'b0;
      rsp_err_d  = 1'b0;
      rsp_data_d = rsp_data_q;
      cmd_err    = 1'b0;
      CmdReady   = 1'b0;
      SPDrive    = DRV_HOLD;
      SPSet      = '0;
      MemAddr    = '0;
      MemWe      = 1'b0;
      MemRe      = 1'b0;
      MemWData   = '0;

      case (state_q)
         S_IDLE: begin
            CmdReady = 1'b1;
            if (CmdValid) begin
               op_d   = CmdOp;
               data_d = CmdData;
               // SPValue here already reflects the previous command: its SP
               // update landed on the edge before the response cycle.
               case (CmdOp)
                  OP_PUSH:         cmd_err = (SPValue == STACK_TOP);
                  OP_POP, OP_PEEK: cmd_err = (SPValue == STACK_BASE);
                  default:         cmd_err = (CmdData < STACK_BASE) || (CmdData > STACK_TOP);
               endcase
               if (cmd_err) begin
                  rsp_vld_d = 1'b1;
                  rsp_err_d = 1'b1;
               end else begin
                  case (CmdOp)
                     OP_PUSH:         state_d = S_WRITE;
                     OP_POP, OP_PEEK: state_d = S_READ;
                     default:         state_d = S_LOAD;
                  endcase
               end
            end
         end
         S_WRITE: begin
            MemAddr   = SPValue;
            MemWData  = data_q;
            MemWe     = 1'b1;
            SPDrive   = DRV_INC;
            rsp_vld_d = 1'b1;
            state_d   = S_IDLE;
         end
         S_READ: begin
            // Top of stack sits one below SP; empty stack was rejected in IDLE.
            MemAddr = SPValue - 32'd1;
            MemRe   = 1'b1;
            SPDrive = (op_q == OP_POP) ? DRV_DEC : DRV_HOLD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            rsp_data_d = MemRData;
            rsp_vld_d  = 1'b1;
            state_d    = S_IDLE;
         end
         S_LOAD: begin
            SPDrive   = DRV_LOAD;
            SPSet     = data_q;
            rsp_vld_d = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign RspValid = rsp_vld_q;
   assign RspErr   = rsp_err_q;
   assign RspData  = rsp_data_q;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

   localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, PEEK = 2'b10, SETSP = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        CmdValid = 1'b0;
   logic [1:0]  CmdOp = 2'b00;
   logic [31:0] CmdData = '0;
   logic        CmdReady;
   logic        RspValid, RspErr;
   logic [31:0] RspData;
   logic [1:0]  SPDrive;
   logic [31:0] SPSet;
   logic [31:0] SPValue = 32'h0000_0F00;
   logic [31:0] MemAddr;
   logic        MemWe, MemRe;
   logic [31:0] MemWData;
   logic [31:0] MemRData = '0;
   logic [31:0] mem [256];

   int checks = 0;
   int errors = 0;

   stack_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .CmdValid(CmdValid), .CmdOp(CmdOp), .CmdData(CmdData), .CmdReady(CmdReady),
      .RspValid(RspValid), .RspErr(RspErr), .RspData(RspData),
      .SPDrive(SPDrive), .SPSet(SPSet), .SPValue(SPValue),
      .MemAddr(MemAddr), .MemWe(MemWe), .MemRe(MemRe),
      .MemWData(MemWData), .MemRData(MemRData)
   );

   always #5 clk = ~clk;

   // Environment: SP register block (not reset, like the real one) and stack RAM.
   always @(posedge clk) begin
      case (SPDrive)
         2'b01:   SPValue <= SPValue + 32'd1;
         2'b10:   SPValue <= SPValue - 32'd1;
         2'b11:   SPValue <= SPSet;
         default: SPValue <= SPValue;
      endcase
      if (MemWe) mem[MemAddr[7:0]] <= MemWData;
      if (MemRe) MemRData <= mem[MemAddr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command; returns in cycle 1 (the cycle after acceptance).
   task automatic send(input logic [1:0] op, input logic [31:0] data);
      int n;
      n = 0;
      while (!CmdReady && n < 10) begin
         tick();
         n++;
      end
      chk("cmd_ready_before_send", {31'd0, CmdReady}, 32'd1);
      CmdValid = 1'b1;
      CmdOp    = op;
      CmdData  = data;
      tick();
      CmdValid = 1'b0;
      #1;
   endtask

   // Full POP/PEEK: checks the WAIT cycle and the response cycle.
   task automatic read_op(input logic [1:0] op, input string tag, input logic [31:0] exp_data,
                          input logic [31:0] exp_sp);
      send(op, 32'd0);
      chk({tag, "_mem_re"}, {31'd0, MemRe}, 32'd1);
      chk({tag, "_drive"}, {30'd0, SPDrive}, (op == POP) ? 32'd2 : 32'd0);
      tick();
      chk({tag, "_wait_novld"}, {31'd0, RspValid}, 32'd0);
      chk({tag, "_wait_drive"}, {30'd0, SPDrive}, 32'd0);
      tick();
      chk({tag, "_vld"}, {31'd0, RspValid}, 32'd1);
      chk({tag, "_err"}, {31'd0, RspErr}, 32'd0);
      chk({tag, "_data"}, RspData, exp_data);
      chk({tag, "_sp"}, SPValue, exp_sp);
   endtask

   // Command rejected on bounds: error pulse in cycle 1, no side effects.
   task automatic err_op(input logic [1:0] op, input logic [31:0] data, input string tag,
                         input logic [31:0] exp_sp);
      logic [31:0] old_data;
      old_data = RspData;
      send(op, data);
      chk({tag, "_vld"}, {31'd0, RspValid}, 32'd1);
      chk({tag, "_err"}, {31'd0, RspErr}, 32'd1);
      chk({tag, "_drive"}, {30'd0, SPDrive}, 32'd0);
      chk({tag, "_mem"}, {30'd0, MemWe, MemRe}, 32'd0);
      chk({tag, "_ready"}, {31'd0, CmdReady}, 32'd1);
      chk({tag, "_rdata"}, RspData, old_data);
      tick();
      chk({tag, "_vld_gone"}, {31'd0, RspValid}, 32'd0);
      chk({tag, "_sp"}, SPValue, exp_sp);
   endtask

   task automatic push_op(input logic [31:0] data, input string tag, input logic [31:0] exp_addr);
      send(PUSH, data);
      chk({tag, "_we"}, {31'd0, MemWe}, 32'd1);
      chk({tag, "_re"}, {31'd0, MemRe}, 32'd0);
      chk({tag, "_addr"}, MemAddr, exp_addr);
      chk({tag, "_wdata"}, MemWData, data);
      chk({tag, "_drive"}, {30'd0, SPDrive}, 32'd1);
      chk({tag, "_busy"}, {31'd0, CmdReady}, 32'd0);
      chk({tag, "_novld"}, {31'd0, RspValid}, 32'd0);
      tick();
      chk({tag, "_vld"}, {31'd0, RspValid}, 32'd1);
      chk({tag, "_err"}, {31'd0, RspErr}, 32'd0);
      chk({tag, "_drive_off"}, {30'd0, SPDrive}, 32'd0);
      chk({tag, "_sp"}, SPValue, exp_addr + 32'd1);
   endtask

   task automatic setsp_op(input logic [31:0] data, input string tag);
      send(SETSP, data);
      chk({tag, "_drive"}, {30'd0, SPDrive}, 32'd3);
      chk({tag, "_set"}, SPSet, data);
      tick();
      chk({tag, "_vld"}, {31'd0, RspValid}, 32'd1);
      chk({tag, "_err"}, {31'd0, RspErr}, 32'd0);
      chk({tag, "_sp"}, SPValue, data);
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      chk("rst_ready", {31'd0, CmdReady}, 32'd1);
      chk("rst_vld", {30'd0, RspValid, RspErr}, 32'd0);
      chk("rst_rdata", RspData, 32'd0);
      chk("rst_drive", {30'd0, SPDrive}, 32'd0);
      chk("rst_mem", {30'd0, MemWe, MemRe}, 32'd0);
      chk("rst_addr", MemAddr, 32'd0);
      chk("rst_set_wdata", SPSet | MemWData, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: first push
      push_op(32'hDEAD_BEEF, "push1", 32'h0000_0F00);

      // 2: back-to-back pushes and pops
      push_op(32'hAAAA_0001, "pushA", 32'h0000_0F01);
      push_op(32'hBBBB_0002, "pushB", 32'h0000_0F02);
      read_op(POP, "popB", 32'hBBBB_0002, 32'h0000_0F02);
      read_op(POP, "popA", 32'hAAAA_0001, 32'h0000_0F01);
      read_op(POP, "pop0", 32'hDEAD_BEEF, 32'h0000_0F00);

      // 3: underflow
      err_op(POP, 32'd0, "pop_empty", 32'h0000_0F00);
      err_op(PEEK, 32'd0, "peek_empty", 32'h0000_0F00);

      // 4: SETSP bounds and overflow
      setsp_op(32'h0000_1000, "setsp_full");
      err_op(PUSH, 32'h1234_5678, "push_full", 32'h0000_1000);
      err_op(SETSP, 32'h0000_1001, "setsp_over", 32'h0000_1000);
      err_op(SETSP, 32'h0000_0EFF, "setsp_under", 32'h0000_1000);
      setsp_op(32'h0000_0F00, "setsp_base");

      // 5: peek leaves SP alone
      push_op(32'h0000_0055, "push55", 32'h0000_0F00);
      read_op(PEEK, "peek55", 32'h0000_0055, 32'h0000_0F01);

      // 6: reset during WAIT of a POP
      send(POP, 32'd0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_vld", {31'd0, RspValid}, 32'd0);
      chk("midrst_rdata", RspData, 32'd0);
      chk("midrst_outs", {28'd0, SPDrive, MemWe, MemRe}, 32'd0);
      chk("midrst_ready", {31'd0, CmdReady}, 32'd1);
      tick();
      chk("midrst_vld_held", {31'd0, RspValid}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("postrst_ready", {31'd0, CmdReady}, 32'd1);
      chk("postrst_vld", {31'd0, RspValid}, 32'd0);
      chk("postrst_sp", SPValue, 32'h0000_0F00);
      push_op(32'h0000_0077, "postrst_push", 32'h0000_0F00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
